// File: rtl/cdc_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
// Shared types and default widths for the toggle-handshake CDC pair
// (cdc_handshake_tx source side and its destination-side responder).
// ---------------------------------------------------------------------------
package cdc_pkg;

    // Default widths shared by the initiator and the responder
    localparam int CDC_DATA_WIDTH     = 32;
    localparam int CDC_SYNC_DEPTH     = 2;
    localparam int CDC_TIMEOUT_CYCLES = 1024;

    // Initiator FSM
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } cdc_hs_tx_state_e;

    // Counter width able to hold the value n
    function automatic int cdc_cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// ---------------------------------------------------------------------------
// cdc_handshake_tx_if
// Groups the upstream valid/ready port and the cross-domain req/ack/data
// signals of the toggle-handshake initiator.
//   master : the initiator (drives S_READY, TX_DATA, TX_REQ, TX_DONE, ERR)
//   slave  : its environment (drives S_DATA, S_VALID, RX_ACK)
// ---------------------------------------------------------------------------
interface cdc_handshake_tx_if
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH = CDC_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] S_DATA;
    logic                  S_VALID;
    logic                  S_READY;
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  TX_REQ;
    logic                  RX_ACK;
    logic                  TX_DONE;
    logic                  ERR;

    modport master (
        input  S_DATA, S_VALID, RX_ACK,
        output S_READY, TX_DATA, TX_REQ, TX_DONE, ERR
    );

    modport slave (
        output S_DATA, S_VALID, RX_ACK,
        input  S_READY, TX_DATA, TX_REQ, TX_DONE, ERR
    );
endinterface

// File: rtl/synchronizer.sv
// ---------------------------------------------------------------------------
// synchronizer
// Single-bit flip-flop chain bringing an asynchronous level into CLK's domain.
//   FF_DEPTH : number of flops; 0 gives a combinational pass-through.
// Ports:
//   CLK   in  destination clock
//   RST_N in  asynchronous active-low reset (chain clears to 0)
//   D     in  asynchronous input level
//   Q     out synchronized level
// ---------------------------------------------------------------------------
module synchronizer #(
    parameter int FF_DEPTH = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);
    generate
        if (FF_DEPTH == 0) begin : g_pass
            assign Q = D;
        end else begin : g_sync
            logic [FF_DEPTH-1:0] sync_q;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= D;
                    for (int i = 1; i < FF_DEPTH; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign Q = sync_q[FF_DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/cdc_handshake_tx.sv
// ---------------------------------------------------------------------------
// cdc_handshake_tx
// Source-side initiator of a two-phase (toggle) req/ack handshake. A word
// accepted on S_VALID/S_READY is registered onto TX_DATA and TX_REQ toggles;
// the block then waits until the synchronized RX_ACK matches TX_REQ, pulses
// TX_DONE and becomes ready again.
//
// Ports:
//   CLK    in  source-domain clock
//   RST_N  in  asynchronous active-low reset
//   hs     cdc_handshake_tx_if.master
//          S_DATA/S_VALID/S_READY : upstream word port
//          TX_DATA/TX_REQ         : to destination (data stable while pending)
//          RX_ACK                 : asynchronous ack level from destination
//          TX_DONE                : one-cycle completion pulse
//          ERR                    : sticky ack-timeout flag
//
// Optional feature: define CDC_HS_TX_TIMEOUT_EN to enable the ack-timeout
// counter driving ERR. Without it ERR is tied low.
//
// Both ends must be reset together: a stale RX_ACK=1 after reset makes the
// next transfer complete spuriously, and this is not detected here.
// ---------------------------------------------------------------------------
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = CDC_DATA_WIDTH,
    parameter int SYNC_DEPTH     = CDC_SYNC_DEPTH,
    parameter int TIMEOUT_CYCLES = CDC_TIMEOUT_CYCLES
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    cdc_handshake_tx_if.master        hs
);
    cdc_hs_tx_state_e      state;
    logic                  s_ready_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_req_q;
    logic                  tx_done_q;
    logic                  ack_sync;
    logic                  accept;

    synchronizer #(
        .FF_DEPTH (SYNC_DEPTH)
    ) u_ack_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (hs.RX_ACK),
        .Q     (ack_sync)
    );

    // s_ready_q is only ever 1 in IDLE, the state check keeps the intent clear
    assign accept = (state == IDLE) && s_ready_q && hs.S_VALID;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            s_ready_q <= 1'b0;
            tx_data_q <= '0;
            tx_req_q  <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= WAIT_ACK;
                        s_ready_q <= 1'b0;
                        tx_data_q <= hs.S_DATA;
                        tx_req_q  <= ~tx_req_q;
                    end else begin
                        // first edge after reset release raises ready
                        s_ready_q <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // ack level catching up with req closes the transfer
                    if (ack_sync == tx_req_q) begin
                        state     <= IDLE;
                        s_ready_q <= 1'b1;
                        tx_done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign hs.S_READY = s_ready_q;
    assign hs.TX_DATA = tx_data_q;
    assign hs.TX_REQ  = tx_req_q;
    assign hs.TX_DONE = tx_done_q;

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int                TO_W   = cdc_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // Counts WAIT_ACK cycles since the last accept, saturating at TO_MAX.
    // ERR is raised on the edge where the count reaches TO_MAX and is only
    // cleared by reset; the FSM keeps waiting regardless.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                to_cnt <= '0;
            end else if (state == WAIT_ACK && to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_MAX - 1'b1) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign hs.ERR = err_q;
`else
    assign hs.ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// ---------------------------------------------------------------------------
// tb_cdc_handshake_tx
// Directed bench for cdc_handshake_tx with SYNC_DEPTH=2, TIMEOUT_CYCLES=8.
// Accepted words are pushed to a scoreboard; the bench-side responder pops
// and compares them when it observes the TX_REQ toggle. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cdc_handshake_tx;
    import cdc_pkg::*;

    localparam int DW = 32;
    localparam int SD = 2;
    localparam int TO = 8;

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic          exp_req = 1'b0;
    logic [DW-1:0] sb[$];

    cdc_handshake_tx_if #(.DATA_WIDTH(DW)) hs ();

    cdc_handshake_tx #(
        .DATA_WIDTH     (DW),
        .SYNC_DEPTH     (SD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .hs    (hs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a word, wait (bounded) for acceptance, log it in the scoreboard.
    task automatic send(input logic [DW-1:0] w);
        int n = 0;
        while (hs.S_READY !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ready_before_send", hs.S_READY, 1'b1);
        hs.S_DATA  = w;
        hs.S_VALID = 1'b1;
        step();
        hs.S_VALID = 1'b0;
        exp_req    = ~exp_req;
        sb.push_back(w);
        chk("tx_req_toggle", hs.TX_REQ, exp_req);
        chk("ready_drop", hs.S_READY, 1'b0);
        chk("done_clear", hs.TX_DONE, 1'b0);
    endtask

    // Responder: receive the word, then toggle RX_ACK after dly cycles.
    task automatic respond(input int dly);
        logic [DW-1:0] w;
        if (sb.size() == 0) begin
            chk("sb_empty", 1'b1, 1'b0);
            return;
        end
        w = sb.pop_front();
        chk("rx_word", hs.TX_DATA, w);
        for (int i = 0; i < dly; i++) step();
        hs.RX_ACK = ~hs.RX_ACK;
    endtask

    // Wait (bounded) for TX_DONE; TX_DATA must hold until then.
    task automatic wait_done(input logic [DW-1:0] held);
        int   lat    = -1;
        logic stable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (hs.TX_DATA !== held) stable = 1'b0;
            if (hs.TX_DONE === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("done_latency", lat, SD + 1);
        chk("tx_data_stable", stable, 1'b1);
        chk("ready_after_done", hs.S_READY, 1'b1);
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        hs.RX_ACK  = 1'b0;
        hs.S_VALID = 1'b0;
        exp_req    = 1'b0;
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [DW-1:0] words [4];
        logic          req_seq [4];
        words   = '{32'h1, 32'h2, 32'h3, 32'h4};
        req_seq = '{1'b1, 1'b0, 1'b1, 1'b0};

        hs.S_DATA  = '0;
        hs.S_VALID = 1'b0;
        hs.RX_ACK  = 1'b0;

        // reset values
        step();
        chk("rst_ready", hs.S_READY, 1'b0);
        chk("rst_req", hs.TX_REQ, 1'b0);
        chk("rst_data", hs.TX_DATA, '0);
        chk("rst_done", hs.TX_DONE, 1'b0);
        chk("rst_err", hs.ERR, 1'b0);
        rst_n = 1'b1;
        step();
        chk("ready_after_release", hs.S_READY, 1'b1);

        // single transfer, with a busy-time word that must be ignored
        send(32'hDEADBEEF);
        chk("tx_data_single", hs.TX_DATA, 32'hDEADBEEF);
        hs.S_DATA  = 32'h12345678;
        hs.S_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("busy_data", hs.TX_DATA, 32'hDEADBEEF);
            chk("busy_req", hs.TX_REQ, exp_req);
        end
        hs.S_VALID = 1'b0;
        respond(0);
        wait_done(32'hDEADBEEF);
        step();
        chk("done_one_cycle", hs.TX_DONE, 1'b0);

        // back-to-back from a clean reset, 3-cycle responder
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            send(words[k]);
            chk("b2b_req_seq", hs.TX_REQ, req_seq[k]);
            respond(3);
            wait_done(words[k]);
        end
        chk("b2b_sb_drained", sb.size(), 0);

        // acknowledge timeout
        send(32'hCAFE0001);
        for (int i = 2; i <= 8; i++) step();
        chk("err_before_timeout", hs.ERR, 1'b0);
        step();
        chk("err_at_timeout", hs.ERR, ERR_EXP);
        respond(0);
        wait_done(32'hCAFE0001);
        chk("err_sticky", hs.ERR, ERR_EXP);

        // mid-transfer reset
        send(32'h55AA55AA);
        step();
        rst_n     = 1'b0;
        hs.RX_ACK = 1'b0;
        #1;
        chk("mid_rst_ready", hs.S_READY, 1'b0);
        chk("mid_rst_req", hs.TX_REQ, 1'b0);
        chk("mid_rst_data", hs.TX_DATA, '0);
        chk("mid_rst_done", hs.TX_DONE, 1'b0);
        chk("mid_rst_err", hs.ERR, 1'b0);
        sb.delete();
        exp_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rst_ready_after", hs.S_READY, 1'b1);
        send(32'h0BADF00D);
        respond(1);
        wait_done(32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side initiator of a two-phase (toggle) request/acknowledge handshake for moving a multi-bit word into another clock domain. It accepts a word on a valid/ready port, holds it stable on `TX_DATA`, toggles `TX_REQ`, and waits for the destination's `RX_ACK` toggle. `RX_ACK` is brought into this domain through the team's single-bit `synchronizer`. The block sits in the source domain and pairs with a destination-side responder, which samples `TX_DATA` after its own synchronized view of `TX_REQ` changes.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the transferred word.
- `SYNC_DEPTH`, 2: flip-flop depth of the `RX_ACK` synchronizer; 0 means pass-through (bench use only).
- `TIMEOUT_CYCLES`, 1024: acknowledge timeout. Used only with `CDC_HS_TX_TIMEOUT_EN`.

Ports:
- `CLK`  in  1  source-domain clock; the only clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `S_DATA`  in  DATA_WIDTH  word to send.
- `S_VALID`  in  1  `S_DATA` is valid.
- `S_READY`  out  1  block can accept a word.
- `TX_DATA`  out  DATA_WIDTH  registered word; stable while a transfer is outstanding.
- `TX_REQ`  out  1  request level; toggles once per transfer.
- `RX_ACK`  in  1  asynchronous acknowledge level from the destination; toggles once per transfer.
- `TX_DONE`  out  1  one-cycle pulse when a transfer completes.
- `ERR`  out  1  sticky acknowledge-timeout flag.

## Operation
- Reset values: `S_READY`=0 during reset and 1 from the first edge after release. `TX_DATA`=0, `TX_REQ`=0, `TX_DONE`=0, `ERR`=0. State is `IDLE`.
- FSM states:
  - `IDLE`: `S_READY`=1.
  - `WAIT_ACK`: `S_READY`=0.
- `IDLE` → `WAIT_ACK` on `S_VALID && S_READY`. On that same edge:
  - `TX_DATA` <= `S_DATA`.
  - `TX_REQ` <= `~TX_REQ`.
- `WAIT_ACK` → `IDLE` when `ack_sync == TX_REQ`, where `ack_sync` is the synchronizer output. On that edge, `TX_DONE` <= 1 for one cycle.
- `S_VALID` is ignored in `WAIT_ACK`. Upstream must hold `S_DATA`/`S_VALID` until accepted (AXI-stream-like rule).
- In `IDLE`, any value of `ack_sync` is ignored.
- `TX_DATA` changes only on an accept edge and never in `WAIT_ACK`.
- Transfers are back-to-back capable:
  - A word presented in the cycle after `TX_DONE` is accepted on the next edge.
  - `S_READY` is a registered state decode, so there is no combinational path from `RX_ACK`.
- Mid-operation reset: all registers return to reset values immediately and any outstanding transfer is abandoned. The protocol requires both ends to be reset together. If `RX_ACK` is still 1 after reset, the next transfer completes spuriously. This is documented as a system constraint, not detected.

## Timing
- Accept edge T: `TX_REQ`/`TX_DATA` update at T; `S_READY` drops in the cycle after T.
- If `RX_ACK` toggles before edge E0:
  - `ack_sync` changes at edge E0+SYNC_DEPTH−1.
  - The FSM returns to `IDLE` and `TX_DONE` pulses at edge E0+SYNC_DEPTH.
  - `S_READY` is 1 in the following cycle.
- With `SYNC_DEPTH`=0, `ack_sync`=`RX_ACK` and completion occurs at E0.
- Minimum source-domain cycles per word: 1 (accept) plus the destination round trip plus `SYNC_DEPTH`.

## Configuration
- `CDC_HS_TX_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on accept and increments each `WAIT_ACK` cycle, saturating.
  - When it reaches `TIMEOUT_CYCLES`, `ERR` sets and stays set until reset.
  - The FSM keeps waiting; no retry and no abort.
- Not defined: `ERR` is tied to 0 and no counter logic exists.

## Structure
- Shared package `cdc_pkg`:
  - `cdc_hs_tx_state_e` enum (`IDLE`, `WAIT_ACK`).
  - Default-width localparams shared with the responder.
- One sub-module instance: `synchronizer` (`FF_DEPTH`=`SYNC_DEPTH`) on `RX_ACK`.
- The FSM, data register and timeout counter live in this module.

## Test plan
- Reset release: during and after reset, `S_READY`=0/1, `TX_REQ`=0, `TX_DATA`=0, `ERR`=0.
- Single transfer, `SYNC_DEPTH`=2:
  - Stimulus: accept 0xDEADBEEF at edge T; bench toggles `RX_ACK` before E0.
  - Required: `TX_REQ`=1 after T; `TX_DATA`=0xDEADBEEF stable through completion; `TX_DONE` pulses at E0+2; `S_READY`=1 after.
- Busy ignore: present 0x12345678 while in `WAIT_ACK` → `TX_DATA` stays 0xDEADBEEF and no second toggle occurs.
- Back-to-back: 4 words 0x1..0x4 with a bench responder of 3-cycle delay → `TX_REQ` sequence 1,0,1,0; four `TX_DONE` pulses; the responder receives 0x1..0x4 in order.
- Timeout, macro on, `TIMEOUT_CYCLES`=8: no ack → `ERR` rises after 8 `WAIT_ACK` cycles. A later ack still completes the transfer and `ERR` stays 1.
- Mid-transfer reset: assert `RST_N`=0 in `WAIT_ACK` → all outputs return to reset values asynchronously; a new transfer after release completes normally.
